// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data-RAM/GPIO slave port.
// Bounded burst tenure, combinational grant, and one-cycle-delayed read-valid per master.
module ram_bus_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic                  s_we,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  owner,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       owner_q, owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;

  assign m0_gnt    = (state_q == ST_OWN0) & m0_req;
  assign m1_gnt    = (state_q == ST_OWN1) & m1_req;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;
  assign rdata     = s_rdata;
  assign busy      = (state_q != ST_IDLE);
  // last_owner resets to 1 so master 0 wins the first tie, but the visible
  // owner output must read 0 until somebody is actually granted.
  assign owner     = owner_q;

  assign rv0_d = m0_gnt & ~m0_we;
  assign rv1_d = m1_gnt & ~m1_we;

  always_comb begin
    s_addr  = '0;
    s_we    = 1'b0;
    s_wdata = '0;
    if (m0_gnt) begin
      s_addr  = m0_addr;
      s_we    = m0_we;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_addr  = m1_addr;
      s_we    = m1_we;
      s_wdata = m1_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_req && (!m1_req || last_owner_q)) begin
          state_d      = ST_OWN0;
          last_owner_d = 1'b0;
          owner_d      = 1'b0;
          burst_cnt_d  = '0;
        end else if (m1_req) begin
          state_d      = ST_OWN1;
          last_owner_d = 1'b1;
          owner_d      = 1'b1;
          burst_cnt_d  = '0;
        end
      end
      ST_OWN0: begin
        if (m0_req) begin
          if (m1_req && (burst_cnt_q == BURST_LAST)) begin
            state_d      = ST_OWN1;
            last_owner_d = 1'b1;
            owner_d      = 1'b1;
            burst_cnt_d  = '0;
          end else if (burst_cnt_q != BURST_LAST) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else if (m1_req) begin
          state_d      = ST_OWN1;
          last_owner_d = 1'b1;
          owner_d      = 1'b1;
          burst_cnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (m1_req) begin
          if (m0_req && (burst_cnt_q == BURST_LAST)) begin
            state_d      = ST_OWN0;
            last_owner_d = 1'b0;
            owner_d      = 1'b0;
            burst_cnt_d  = '0;
          end else if (burst_cnt_q != BURST_LAST) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else if (m0_req) begin
          state_d      = ST_OWN0;
          last_owner_d = 1'b0;
          owner_d      = 1'b0;
          burst_cnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      burst_cnt_q  <= '0;
      rv0_q        <= 1'b0;
      rv1_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rv0_q        <= rv0_d;
      rv1_q        <= rv1_d;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter (MAX_BURST=4): reset, contention,
// release handover, single read, write mux and asynchronous reset mid-read.
module tb_ram_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata, rdata;
  logic        s_we, owner, busy;

  int n_cmp = 0;
  int n_err = 0;

  ram_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .rdata(rdata), .owner(owner), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected summary before 200000");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 units after a rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".m0_gnt"}, 64'(m0_gnt), 64'd0);
    chk({tag, ".m1_gnt"}, 64'(m1_gnt), 64'd0);
    chk({tag, ".m0_rvalid"}, 64'(m0_rvalid), 64'd0);
    chk({tag, ".m1_rvalid"}, 64'(m1_rvalid), 64'd0);
    chk({tag, ".s_we"}, 64'(s_we), 64'd0);
    chk({tag, ".s_addr"}, 64'(s_addr), 64'd0);
    chk({tag, ".s_wdata"}, 64'(s_wdata), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".owner"}, 64'(owner), 64'd0);
  endtask

  initial begin
    int pat_a [9];
    int pat_b [5];
    pat_a = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    pat_b = '{1, 1, 1, 1, 0};

    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200; m1_wdata = 32'h0;
    s_rdata = 32'h0;

    // Reset held with both masters requesting
    step(); step(); step();
    #1;
    chk_idle_outputs("rst_hold");

    step();
    rst = 1'b1;
    #1;
    chk("rel.m0_gnt_same_cycle", 64'(m0_gnt), 64'd0);

    // Contention: grants 0,0,0,0,1,1,1,1,0 with no idle cycles
    for (int i = 0; i < 9; i++) begin
      step();
      s_rdata = 32'hA000_0000 + 32'(i);
      #1;
      chk($sformatf("cont%0d.m0_gnt", i), 64'(m0_gnt), 64'(pat_a[i] == 0));
      chk($sformatf("cont%0d.m1_gnt", i), 64'(m1_gnt), 64'(pat_a[i] == 1));
      chk($sformatf("cont%0d.owner", i), 64'(owner), 64'(pat_a[i]));
      chk($sformatf("cont%0d.s_addr", i), 64'(s_addr), (pat_a[i] == 0) ? 64'h100 : 64'h200);
      if (i == 4) chk("cont4.m0_rvalid_after_switch", 64'(m0_rvalid), 64'd1);
      if (i == 8) chk("cont8.m1_rvalid_after_switch", 64'(m1_rvalid), 64'd1);
    end

    // Release: m0 makes a second transfer, then drops req
    step();
    #1;
    chk("release.m0_gnt2", 64'(m0_gnt), 64'd1);
    step();
    m0_req = 1'b0;
    #1;
    chk("release.m0_gnt_dropped", 64'(m0_gnt), 64'd0);
    chk("release.m1_gnt_wait", 64'(m1_gnt), 64'd0);
    step();
    m0_req = 1'b1;
    #1;
    chk("release.m1_gnt", 64'(m1_gnt), 64'd1);
    chk("release.owner", 64'(owner), 64'd1);
    chk("release.m0_rvalid", 64'(m0_rvalid), 64'd0);
    for (int i = 1; i < 5; i++) begin
      step();
      #1;
      chk($sformatf("rel_burst%0d.m0_gnt", i), 64'(m0_gnt), 64'(pat_b[i] == 0));
      chk($sformatf("rel_burst%0d.m1_gnt", i), 64'(m1_gnt), 64'(pat_b[i] == 1));
    end

    // Both idle
    step();
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    chk("idle.m0_gnt", 64'(m0_gnt), 64'd0);
    chk("idle.s_addr", 64'(s_addr), 64'd0);
    chk("idle.m0_rvalid_last", 64'(m0_rvalid), 64'd1);
    step();
    #1;
    chk("idle.busy", 64'(busy), 64'd0);
    chk("idle.owner", 64'(owner), 64'd0);
    chk("idle.m0_rvalid", 64'(m0_rvalid), 64'd0);

    // Single master 1 read of 0x10
    step();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
    #1;
    chk("rd1.gnt_not_yet", 64'(m1_gnt), 64'd0);
    step();
    #1;
    chk("rd1.m1_gnt", 64'(m1_gnt), 64'd1);
    chk("rd1.s_addr", 64'(s_addr), 64'h10);
    chk("rd1.s_we", 64'(s_we), 64'd0);
    chk("rd1.busy", 64'(busy), 64'd1);
    step();
    m1_req = 1'b0;
    s_rdata = 32'hCAFE_0010;
    #1;
    chk("rd1.m1_rvalid", 64'(m1_rvalid), 64'd1);
    chk("rd1.rdata", 64'(rdata), 64'hCAFE_0010);
    chk("rd1.m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("rd1.m1_gnt_off", 64'(m1_gnt), 64'd0);
    step();
    #1;
    chk("rd1.m1_rvalid_off", 64'(m1_rvalid), 64'd0);
    chk("rd1.owner_kept", 64'(owner), 64'd1);
    chk("rd1.busy_off", 64'(busy), 64'd0);

    // Write mux: m0 writes 0xDEADBEEF to 0x20, m1 waiting
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hDEAD_BEEF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30; m1_wdata = 32'h1111;
    #1;
    chk("wr.nogrant.s_we", 64'(s_we), 64'd0);
    chk("wr.nogrant.s_wdata", 64'(s_wdata), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      chk($sformatf("wr%0d.m0_gnt", i), 64'(m0_gnt), 64'd1);
      chk($sformatf("wr%0d.m1_gnt", i), 64'(m1_gnt), 64'd0);
      chk($sformatf("wr%0d.s_we", i), 64'(s_we), 64'd1);
      chk($sformatf("wr%0d.s_wdata", i), 64'(s_wdata), 64'hDEAD_BEEF);
      chk($sformatf("wr%0d.s_addr", i), 64'(s_addr), 64'h20);
    end
    step();
    m0_req = 1'b0;
    #1;
    chk("wr.drop.s_we", 64'(s_we), 64'd0);
    chk("wr.drop.s_addr", 64'(s_addr), 64'd0);
    chk("wr.drop.m0_rvalid", 64'(m0_rvalid), 64'd0);
    step();
    #1;
    chk("wr.m1.gnt", 64'(m1_gnt), 64'd1);
    chk("wr.m1.s_addr", 64'(s_addr), 64'h30);
    chk("wr.m1.s_we", 64'(s_we), 64'd0);
    chk("wr.m1.s_wdata", 64'(s_wdata), 64'h1111);

    // Asynchronous reset on the cycle after m1's granted read
    m0_req = 1'b1;
    step();
    chk("rstmid.m1_rvalid_before", 64'(m1_rvalid), 64'd1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("rstmid");
    step();
    rst = 1'b1;
    #1;
    chk("rstmid.rel.m0_gnt", 64'(m0_gnt), 64'd0);
    step();
    #1;
    chk("rstmid.restart.m0_gnt", 64'(m0_gnt), 64'd1);
    chk("rstmid.restart.m1_gnt", 64'(m1_gnt), 64'd0);
    chk("rstmid.restart.owner", 64'(owner), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
